wf_random_5_checker: RTL

WF_RANDOM_5_CHECKER -- requirements
Module: WF_random_5_checker

---
 rtl/wf_random_5_checker.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/wf_random_5_checker.sv
// ---------------------------------------------------------------------------
// wf_random_5_checker
//   Lock/loss checker for a 5-bit pseudo-random word stream.
//
//   In SEARCH, every enabled sample reseeds the predictor from data_in.
//   After LOCK_MATCHES consecutive correct predictions, the checker locks.
//   Once locked, the predictor flywheels on its own output.
//   LOSS_ERRORS consecutive mismatches while locked drop the lock.
//   Mismatches while locked pulse 'error' and are counted.
//
//   Optional feature macro: WF_RANDOM_5_CHECKER_STATS_EN
//     defined   : error_count / error_sat / clear are implemented
//     undefined : error_count and error_sat are tied to 0, clear is ignored
//
// Ports
//   clk          in   single clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   enable       in   data_in valid this cycle
//   data_in[4:0] in   received pseudo-random word
//   clear        in   synchronous clear of error_count / error_sat
//   locked       out  checker synchronised (registered)
//   error        out  one-cycle pulse, mismatch while locked (registered)
//   error_count  out  saturating count of mismatches while locked
//   error_sat    out  error_count has reached all-ones
// ---------------------------------------------------------------------------
module wf_random_5_checker #(
  parameter int LOCK_MATCHES = 4,
  parameter int LOSS_ERRORS  = 3,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [4:0]           data_in,
  input  logic                 clear,
  output logic                 locked,
  output logic                 error,
  output logic [CNT_WIDTH-1:0] error_count,
  output logic                 error_sat
);

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  localparam logic [3:0] LP_LOCK = 4'(LOCK_MATCHES);
  localparam logic [3:0] LP_LOSS = 4'(LOSS_ERRORS);

  state_t     r_state, w_state_next;
  logic [4:0] r_expected, w_expected_next;
  logic       r_seeded, w_seeded_next;
  logic [3:0] r_match_cnt, w_match_cnt_next;
  logic [3:0] r_miss_cnt, w_miss_cnt_next;
  logic       r_error, w_error_next;
  logic       w_count_err;
  logic [3:0] w_match_inc;
  logic [3:0] w_miss_inc;

  // Successor of a word in the sequence; the all-zero word is a lock-up
  // state of the recurrence, so it is forced onto 5'h1F instead.
  function automatic logic [4:0] f_next(input logic [4:0] d);
    logic [4:0] n;
    n[4] = d[4] ^ d[1];
    n[3] = d[3] ^ d[0];
    n[2] = d[2] ^ n[4];
    n[1] = d[1] ^ n[3];
    n[0] = d[0] ^ n[2];
    if (d == 5'h00) n = 5'h1F;
    return n;
  endfunction

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_SEARCH;
      r_expected  <= 5'h00;
      r_seeded    <= 1'b0;
      r_match_cnt <= 4'd0;
      r_miss_cnt  <= 4'd0;
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_expected  <= w_expected_next;
      r_seeded    <= w_seeded_next;
      r_match_cnt <= w_match_cnt_next;
      r_miss_cnt  <= w_miss_cnt_next;
      r_error     <= w_error_next;
    end
  end

  assign w_match_inc = r_match_cnt + 4'd1;
  assign w_miss_inc  = r_miss_cnt + 4'd1;

  // Next-state logic
  always_comb begin
    w_state_next     = r_state;
    w_expected_next  = r_expected;
    w_seeded_next    = r_seeded;
    w_match_cnt_next = r_match_cnt;
    w_miss_cnt_next  = r_miss_cnt;
    w_error_next     = 1'b0;
    w_count_err      = 1'b0;
    if (enable) begin
      case (r_state)
        ST_SEARCH: begin
          // Always reseed from the received word while searching.
          w_expected_next = f_next(data_in);
          if (!r_seeded) begin
            w_seeded_next    = 1'b1;
            w_match_cnt_next = 4'd0;
          end else if (data_in == r_expected) begin
            w_match_cnt_next = w_match_inc;
            if (w_match_inc == LP_LOCK) begin
              w_state_next    = ST_LOCKED;
              w_miss_cnt_next = 4'd0;
            end
          end else begin
            w_match_cnt_next = 4'd0;
          end
        end
        ST_LOCKED: begin
          // Flywheel: a corrupted word must not disturb the predictor.
          w_expected_next = f_next(r_expected);
          if (data_in != r_expected) begin
            w_error_next    = 1'b1;
            w_count_err     = 1'b1;
            w_miss_cnt_next = w_miss_inc;
            if (w_miss_inc == LP_LOSS) begin
              w_state_next     = ST_SEARCH;
              w_seeded_next    = 1'b0;
              w_match_cnt_next = 4'd0;
              w_miss_cnt_next  = 4'd0;
            end
          end else begin
            w_miss_cnt_next = 4'd0;
          end
        end
        default: begin
          w_state_next = ST_SEARCH;
        end
      endcase
    end
  end

  // Outputs come straight from registers
  always_comb begin
    locked = (r_state == ST_LOCKED);
    error  = r_error;
  end

`ifdef WF_RANDOM_5_CHECKER_STATS_EN
  logic [CNT_WIDTH-1:0] r_error_count;
  logic                 r_error_sat;
  logic [CNT_WIDTH-1:0] w_count_inc;

  assign w_count_inc = r_error_count + CNT_WIDTH'(1);

  // Clear has priority over a mismatch counted on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_error_count <= '0;
      r_error_sat   <= 1'b0;
    end else if (clear) begin
      r_error_count <= '0;
      r_error_sat   <= 1'b0;
    end else if (w_count_err && (r_error_count != '1)) begin
      r_error_count <= w_count_inc;
      if (w_count_inc == '1) r_error_sat <= 1'b1;
    end
  end

  assign error_count = r_error_count;
  assign error_sat   = r_error_sat;
`else
  logic w_unused_stats;
  assign w_unused_stats = &{1'b0, clear, w_count_err};
  assign error_count    = '0;
  assign error_sat      = 1'b0;
`endif

endmodule
